soc_rst_seq: RTL and testbench

Reset sequencer for the Cheshire FPGA top, sitting directly upstream of the SoC reset input and downstream of the DRAM wrapper's calibration status. Its job is to hold the SoC in reset until DRAM calibration completes. It then releases peripheral reset first and core reset a fixed number of cycles later. After that it re-sequences on a debounced board reset button or on loss of calibration. Its outputs replace the plain reset-generator output feeding the SoC and peripherals such as the fan controller and the RTC divider.

---
 rtl/soc_rst_seq_pkg.sv | 24 ++
 rtl/soc_rst_seq_btn_debounce.sv | 49 ++++
 rtl/sync.sv | 25 ++
 rtl/soc_rst_seq.sv | 154 +++++++++++++++
 tb/tb_soc_rst_seq.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_rst_seq_pkg.sv
// Shared types and default constants for the Cheshire FPGA reset sequencer.
// Imported by the sequencer top and its button debouncer.
package soc_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CALIB = 3'd0,
    ST_HOLD       = 3'd1,
    ST_PERIPH     = 3'd2,
    ST_RUN        = 3'd3,
    ST_BTN_WAIT   = 3'd4
  } rst_seq_state_e;

  localparam int unsigned DefSyncStages         = 2;
  localparam int unsigned DefDebounceCycles     = 50000;
  localparam int unsigned DefHoldCycles         = 64;
  localparam int unsigned DefPeriphLeadCycles   = 16;
  localparam int unsigned DefCalibTimeoutCycles = 2 ** 24;

  // Counter width for a given limit; a limit of 1 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/soc_rst_seq_btn_debounce.sv
// Synchronizes the bouncing board button and accepts a new level only after
// it has disagreed with the current debounced level for DebounceCycles cycles.
module btn_debounce
  import soc_rst_seq_pkg::*;
#(
  parameter int unsigned SyncStages     = DefSyncStages,
  parameter int unsigned DebounceCycles = DefDebounceCycles
) (
  input  logic soc_clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_btn_db
);

  localparam int unsigned         CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0]     CntLast = CntW'(DebounceCycles - 1);

  logic            w_btn_sync;
  logic            r_btn_db;
  logic [CntW-1:0] r_cnt;

  sync #(
    .STAGES     (SyncStages),
    .ResetValue (1'b0)
  ) u_btn_sync (
    .clk_i    (soc_clk),
    .rst_ni   (rst_n),
    .serial_i (i_btn),
    .serial_o (w_btn_sync)
  );

  // Any cycle of agreement restarts the stability window.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db <= 1'b0;
      r_cnt    <= '0;
    end else if (w_btn_sync == r_btn_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_btn_db <= ~r_btn_db;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_btn_db = r_btn_db;

endmodule

// File: rtl/sync.sv
// Multi-flop synchronizer with the common_cells interface.
// STAGES must be at least 2.
module sync #(
  parameter int unsigned STAGES     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] r_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync_q <= {STAGES{ResetValue}};
    end else begin
      r_sync_q <= {r_sync_q[STAGES-2:0], serial_i};
    end
  end

  assign serial_o = r_sync_q[STAGES-1];

endmodule

// File: rtl/soc_rst_seq.sv
// Reset sequencer: holds the SoC in reset until DRAM calibration, releases
// peripherals ahead of the core, and re-sequences on button press or calib loss.
module soc_rst_seq
  import soc_rst_seq_pkg::*;
#(
  parameter int unsigned SyncStages         = DefSyncStages,
  parameter int unsigned DebounceCycles     = DefDebounceCycles,
  parameter int unsigned HoldCycles         = DefHoldCycles,
  parameter int unsigned PeriphLeadCycles   = DefPeriphLeadCycles,
  parameter int unsigned CalibTimeoutCycles = DefCalibTimeoutCycles
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic       test_mode_i,
  input  logic       calib_done_i,
  input  logic       btn_i,
  output logic       periph_rst_no,
  output logic       soc_rst_no,
  output logic       calib_err_o,
  output logic [7:0] reseq_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned HoldW = cnt_width(HoldCycles);
  localparam int unsigned LeadW = cnt_width(PeriphLeadCycles);
  localparam int unsigned CalW  = cnt_width(CalibTimeoutCycles);
  localparam int unsigned HlW   = (HoldW > LeadW) ? HoldW : LeadW;
  localparam int unsigned CntW  = (HlW > CalW) ? HlW : CalW;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] LeadLast = CntW'(PeriphLeadCycles - 1);
  localparam logic [CntW-1:0] CalLast  = CntW'(CalibTimeoutCycles - 1);

  rst_seq_state_e  r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_periph_rst_n, r_soc_rst_n, r_calib_err, w_calib_err_d;
  logic [7:0]      r_reseq_cnt, w_reseq_cnt_d;
  logic            r_btn_db_q;
  logic            w_calib_sync, w_btn_db, w_btn_rise, w_btn_fall, w_abort;

  sync #(
    .STAGES     (SyncStages),
    .ResetValue (1'b0)
  ) u_calib_sync (
    .clk_i    (soc_clk),
    .rst_ni   (rst_n),
    .serial_i (calib_done_i),
    .serial_o (w_calib_sync)
  );

  btn_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_btn_debounce (
    .soc_clk  (soc_clk),
    .rst_n    (rst_n),
    .i_btn    (btn_i),
    .o_btn_db (w_btn_db)
  );

  assign w_btn_rise = w_btn_db & ~r_btn_db_q;
  assign w_btn_fall = ~w_btn_db & r_btn_db_q;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_calib_err_d = r_calib_err;
    w_abort       = 1'b0;
    case (r_state)
      ST_WAIT_CALIB: begin
        if (w_calib_sync) begin
          w_state_d = ST_HOLD;
          w_cnt_d   = '0;
        end else if (r_cnt == CalLast) begin
          w_calib_err_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HoldLast) begin
          w_state_d = ST_PERIPH;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_PERIPH: begin
        if (r_cnt == LeadLast) begin
          w_state_d = ST_RUN;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_state_d = ST_RUN;
      end
      ST_BTN_WAIT: begin
        if (w_btn_fall) begin
          w_state_d = ST_HOLD;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = ST_WAIT_CALIB;
        w_cnt_d   = '0;
      end
    endcase

    // Aborts override the normal progression; calib loss wins over the button.
    if (r_state != ST_WAIT_CALIB) begin
      if (!w_calib_sync) begin
        w_state_d = ST_WAIT_CALIB;
        w_cnt_d   = '0;
        w_abort   = (r_state == ST_HOLD) || (r_state == ST_PERIPH) || (r_state == ST_RUN);
      end else if (w_btn_rise && (r_state != ST_BTN_WAIT)) begin
        w_state_d = ST_BTN_WAIT;
        w_cnt_d   = '0;
        w_abort   = (r_state == ST_HOLD) || (r_state == ST_PERIPH) || (r_state == ST_RUN);
      end
    end

    w_reseq_cnt_d = (w_abort && (r_reseq_cnt != 8'hFF)) ? r_reseq_cnt + 8'd1 : r_reseq_cnt;
  end

  // Reset outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_WAIT_CALIB;
      r_cnt          <= '0;
      r_periph_rst_n <= 1'b0;
      r_soc_rst_n    <= 1'b0;
      r_calib_err    <= 1'b0;
      r_reseq_cnt    <= 8'd0;
      r_btn_db_q     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_periph_rst_n <= (w_state_d == ST_PERIPH) || (w_state_d == ST_RUN);
      r_soc_rst_n    <= (w_state_d == ST_RUN);
      r_calib_err    <= w_calib_err_d;
      r_reseq_cnt    <= w_reseq_cnt_d;
      r_btn_db_q     <= w_btn_db;
    end
  end

  assign periph_rst_no = test_mode_i ? rst_n : r_periph_rst_n;
  assign soc_rst_no    = test_mode_i ? rst_n : r_soc_rst_n;
  assign calib_err_o   = r_calib_err;
  assign reseq_cnt_o   = r_reseq_cnt;
  assign state_o       = r_state;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Bench for soc_rst_seq: directed scenarios plus randomized calib/button traffic,
// checked every cycle against a sample-history model of the sequencing rules.
module tb_soc_rst_seq;

  localparam int TB_S = 2;
  localparam int TB_H = 8;
  localparam int TB_L = 4;
  localparam int TB_D = 16;
  localparam int TB_T = 1000;

  localparam int M_WAIT = 0;
  localparam int M_SEQ  = 1;
  localparam int M_BTN  = 2;

  logic       soc_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_mode_i = 1'b0;
  logic       calib_done_i = 1'b0;
  logic       btn_i = 1'b0;
  logic       periph_rst_no, soc_rst_no, calib_err_o;
  logic [7:0] reseq_cnt_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  soc_rst_seq #(
    .SyncStages         (TB_S),
    .DebounceCycles     (TB_D),
    .HoldCycles         (TB_H),
    .PeriphLeadCycles   (TB_L),
    .CalibTimeoutCycles (TB_T)
  ) dut (
    .soc_clk       (soc_clk),
    .rst_n         (rst_n),
    .test_mode_i   (test_mode_i),
    .calib_done_i  (calib_done_i),
    .btn_i         (btn_i),
    .periph_rst_no (periph_rst_no),
    .soc_rst_no    (soc_rst_no),
    .calib_err_o   (calib_err_o),
    .reseq_cnt_o   (reseq_cnt_o),
    .state_o       (state_o)
  );

  // ---------------- clock ----------------
  always #5 soc_clk = ~soc_clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Synchronizers are modelled as a delay line of raw samples, the debouncer as a
  // window over the most recent synchronized samples, the sequence as elapsed time.
  int   m_mode = M_WAIT;
  int   m_t = 0;
  int   m_wait = 0;
  bit   m_err = 0;
  int   m_reseq = 0;
  bit   m_db = 0;
  bit   m_db_prev = 0;
  bit   m_cal_line[$];
  bit   m_btn_line[$];
  bit   m_btn_hist[$];

  always @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_WAIT; m_t = 0; m_wait = 0; m_err = 0; m_reseq = 0;
      m_db = 0; m_db_prev = 0;
      m_cal_line = {}; m_btn_line = {}; m_btn_hist = {};
      for (int i = 0; i < TB_S; i++) begin
        m_cal_line.push_back(1'b0);
        m_btn_line.push_back(1'b0);
      end
    end else begin
      bit cal_s, btn_s, rise, fall, all_differ;
      cal_s = m_cal_line[0];
      btn_s = m_btn_line[0];
      rise  = m_db && !m_db_prev;
      fall  = !m_db && m_db_prev;

      if (m_mode == M_WAIT) begin
        if (cal_s) begin
          m_mode = M_SEQ; m_t = 0;
        end else begin
          if (m_wait >= TB_T - 1) m_err = 1;
          m_wait++;
        end
      end else if (!cal_s) begin
        if (m_mode == M_SEQ && m_reseq < 255) m_reseq++;
        m_mode = M_WAIT; m_wait = 0;
      end else if (rise && m_mode != M_BTN) begin
        if (m_reseq < 255) m_reseq++;
        m_mode = M_BTN;
      end else if (m_mode == M_BTN) begin
        if (fall) begin m_mode = M_SEQ; m_t = 0; end
      end else if (m_t < TB_H + TB_L) begin
        m_t++;
      end

      // Debounced level flips once the last D synced samples all disagree with it.
      m_db_prev = m_db;
      m_btn_hist.push_back(btn_s);
      if (m_btn_hist.size() > TB_D) void'(m_btn_hist.pop_front());
      all_differ = (m_btn_hist.size() == TB_D);
      foreach (m_btn_hist[i]) if (m_btn_hist[i] == m_db) all_differ = 0;
      if (all_differ) begin
        m_db = !m_db;
        m_btn_hist = {};
      end

      m_cal_line.push_back(calib_done_i); void'(m_cal_line.pop_front());
      m_btn_line.push_back(btn_i);        void'(m_btn_line.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge soc_clk) begin
    logic e_periph, e_soc;
    logic [2:0] e_state;
    e_periph = (m_mode == M_SEQ) && (m_t >= TB_H);
    e_soc    = (m_mode == M_SEQ) && (m_t >= TB_H + TB_L);
    if (m_mode == M_WAIT)     e_state = 3'd0;
    else if (m_mode == M_BTN) e_state = 3'd4;
    else if (m_t < TB_H)      e_state = 3'd1;
    else if (m_t < TB_H + TB_L) e_state = 3'd2;
    else                      e_state = 3'd3;
    if (test_mode_i) begin
      e_periph = rst_n;
      e_soc    = rst_n;
    end
    check("cyc_periph_rst_no", 32'(periph_rst_no), 32'(e_periph));
    check("cyc_soc_rst_no",    32'(soc_rst_no),    32'(e_soc));
    check("cyc_calib_err_o",   32'(calib_err_o),   32'(m_err));
    check("cyc_reseq_cnt_o",   32'(reseq_cnt_o),   32'(m_reseq));
    check("cyc_state_o",       32'(state_o),       32'(e_state));
  end

  // Counts entries into BTN_WAIT as seen on the debug port.
  int       btn_entries = 0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge soc_clk) begin
    if (state_o == 3'd4 && prev_state != 3'd4) btn_entries++;
    prev_state = state_o;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge soc_clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state_o != s && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(state_o), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int entries0, run;

    // Reset state
    #12;
    check("rst_periph", 32'(periph_rst_no), 32'd0);
    check("rst_soc",    32'(soc_rst_no),    32'd0);
    check("rst_err",    32'(calib_err_o),   32'd0);
    check("rst_reseq",  32'(reseq_cnt_o),   32'd0);
    check("rst_state",  32'(state_o),       32'd0);
    #10 rst_n = 1'b1;

    // Calib before edge 10: periph at edge 20, soc at edge 24
    step(9);
    calib_done_i = 1'b1;
    step(10);
    check("s1_periph_e19", 32'(periph_rst_no), 32'd0);
    step(1);
    check("s1_periph_e20", 32'(periph_rst_no), 32'd1);
    check("s1_soc_e20",    32'(soc_rst_no),    32'd0);
    step(3);
    check("s1_soc_e23",    32'(soc_rst_no),    32'd0);
    step(1);
    check("s1_soc_e24",    32'(soc_rst_no),    32'd1);
    check("s1_reseq",      32'(reseq_cnt_o),   32'd0);

    // Bouncing button, then a clean press and release
    entries0 = btn_entries;
    for (int i = 0; i < 40; i++) begin
      btn_i = ((i / 3) % 2 == 0);
      step(1);
    end
    btn_i = 1'b1;
    step(30);
    btn_i = 1'b0;
    step(40);
    check("s2_btn_entries", 32'(btn_entries - entries0), 32'd1);
    check("s2_periph",      32'(periph_rst_no), 32'd1);
    check("s2_soc",         32'(soc_rst_no),    32'd1);
    check("s2_reseq",       32'(reseq_cnt_o),   32'd1);

    // Calib loss in RUN, then again during PERIPH
    calib_done_i = 1'b0;
    step(4);
    check("s3_state_wait", 32'(state_o),     32'd0);
    check("s3_reseq_run",  32'(reseq_cnt_o), 32'd2);
    calib_done_i = 1'b1;
    wait_state(3'd2, 40, "s3_reach_periph");
    calib_done_i = 1'b0;
    step(2);
    check("s3_periph_before", 32'(periph_rst_no), 32'd1);
    step(1);
    check("s3_periph_after",  32'(periph_rst_no), 32'd0);
    check("s3_soc_after",     32'(soc_rst_no),    32'd0);
    check("s3_state_after",   32'(state_o),       32'd0);
    check("s3_reseq_periph",  32'(reseq_cnt_o),   32'd3);

    // rst_n pulse in RUN, then the full sequence again
    calib_done_i = 1'b1;
    wait_state(3'd3, 60, "s5_reach_run");
    #1 rst_n = 1'b0;
    #1;
    check("s5_async_periph", 32'(periph_rst_no), 32'd0);
    check("s5_async_soc",    32'(soc_rst_no),    32'd0);
    check("s5_async_reseq",  32'(reseq_cnt_o),   32'd0);
    check("s5_async_state",  32'(state_o),       32'd0);
    #4 rst_n = 1'b1;
    step(10);
    check("s5_periph_e10", 32'(periph_rst_no), 32'd0);
    step(1);
    check("s5_periph_e11", 32'(periph_rst_no), 32'd1);
    step(4);
    check("s5_soc_e15",    32'(soc_rst_no),    32'd1);

    // Calibration timeout
    calib_done_i = 1'b0;
    do_reset();
    step(999);
    check("s4_err_e999",  32'(calib_err_o), 32'd0);
    step(1);
    check("s4_err_e1000", 32'(calib_err_o), 32'd1);
    step(50);
    calib_done_i = 1'b1;
    step(20);
    check("s4_periph_late", 32'(periph_rst_no), 32'd1);
    check("s4_soc_late",    32'(soc_rst_no),    32'd1);
    check("s4_err_sticky",  32'(calib_err_o),   32'd1);

    // Test-mode bypass and reseq saturation
    calib_done_i = 1'b0;
    do_reset();
    step(5);
    test_mode_i = 1'b1;
    #1;
    check("s6_tm_periph_hi", 32'(periph_rst_no), 32'd1);
    check("s6_tm_soc_hi",    32'(soc_rst_no),    32'd1);
    rst_n = 1'b0;
    #1;
    check("s6_tm_periph_lo", 32'(periph_rst_no), 32'd0);
    check("s6_tm_soc_lo",    32'(soc_rst_no),    32'd0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      calib_done_i = 1'b1;
      step(4);
      calib_done_i = 1'b0;
      step(4);
    end
    check("s6_reseq_sat", 32'(reseq_cnt_o), 32'd255);
    test_mode_i = 1'b0;
    #1;
    check("s6_periph_no_tm", 32'(periph_rst_no), 32'd0);

    // Randomized calib / button traffic
    do_reset();
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (calib_done_i ? ($urandom_range(0, 99) < 1) : ($urandom_range(0, 99) < 5))
        calib_done_i = ~calib_done_i;
      if (run == 0) begin
        btn_i = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 40);
      end
      run--;
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
